abc_seq: RTL and testbench

Sequencer for the ABC keystream datapath (LFSR, adder, B, pi, C chain). It loads the key/IV seed into the core word by word and runs the discarded warm-up rounds. It then streams a programmed number of keystream words to a consumer over a valid/ready handshake, stalling the core whenever the consumer back-pressures. It sits between the keystream core and the host/consumer logic inside the cipher top level.

---
 rtl/abc_seq_if.sv | 48 ++++
 rtl/abc_seq.sv | 150 +++++++++++++++
 tb/tb_abc_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/abc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : abc_seq_if
// Purpose  : Handshake and datapath bundle between the ABC sequencer, the
//            key source, the keystream core and the keystream consumer.
// Signals  : key_valid/key_ready/key_data  seed word stream into sequencer
//            core_load/core_seed/core_en   control towards keystream core
//            core_ks                       current core keystream output
//            ks_valid/ks_ready/ks_data     keystream stream to consumer
//            pt_data                       plaintext word (ABC_SEQ_XOR_EN only)
// Modports : master = sequencer side, slave = environment side
// Config   : ABC_SEQ_XOR_EN adds pt_data
// Revision : 1.0 - initial release
// ============================================================================
interface abc_seq_if #(
  parameter int WIDTH = 32
);
  logic             key_valid;
  logic             key_ready;
  logic [WIDTH-1:0] key_data;
  logic             core_load;
  logic [WIDTH-1:0] core_seed;
  logic             core_en;
  logic [WIDTH-1:0] core_ks;
  logic             ks_valid;
  logic             ks_ready;
  logic [WIDTH-1:0] ks_data;
`ifdef ABC_SEQ_XOR_EN
  logic [WIDTH-1:0] pt_data;
`endif

  modport master (
`ifdef ABC_SEQ_XOR_EN
    input  pt_data,
`endif
    input  key_valid, key_data, core_ks, ks_ready,
    output key_ready, core_load, core_seed, core_en, ks_valid, ks_data
  );

  modport slave (
`ifdef ABC_SEQ_XOR_EN
    output pt_data,
`endif
    output key_valid, key_data, core_ks, ks_ready,
    input  key_ready, core_load, core_seed, core_en, ks_valid, ks_data
  );
endinterface
`default_nettype wire

// File: rtl/abc_seq.sv
`default_nettype none
// ============================================================================
// Module   : abc_seq
// Purpose  : Sequencer for the ABC keystream core. Loads KEY_WORDS seed
//            words, runs WARMUP discarded core steps, then streams msg_len
//            keystream words to a consumer, stalling the core on
//            back-pressure.
// Ports    : clock    rising-edge clock
//            reset    asynchronous active-low reset
//            start    session request, sampled only while idle
//            msg_len  number of keystream words, latched with start
//            busy     high whenever not idle
//            done     one-cycle pulse closing a session
//            bus      abc_seq_if.master (key, core and keystream signals)
// Config   : ABC_SEQ_XOR_EN - when defined, ks_data = core_ks ^ pt_data
// Revision : 1.0 - initial release
// ============================================================================
module abc_seq #(
  parameter int WIDTH     = 32,
  parameter int KEY_WORDS = 4,
  parameter int WARMUP    = 32,
  parameter int LEN_W     = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic [LEN_W-1:0] msg_len,
  output logic                  busy,
  output logic                  done,
  abc_seq_if.master             bus
);

  // One counter serves both the seed-word count and the warm-up count.
  localparam int c_CNT_MAX = (KEY_WORDS > WARMUP) ? KEY_WORDS : WARMUP;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_KEY_LAST  = c_CNT_W'(KEY_WORDS - 1);
  localparam logic [c_CNT_W-1:0] c_WARM_LAST = c_CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // With no warm-up the last seed word leads straight into streaming.
  localparam state_t c_AFTER_LOAD = (WARMUP == 0) ? S_RUN : S_WARMUP;

  state_t             r_state;
  state_t             w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0]   r_remain;
  logic               r_ks_valid;
  logic [WIDTH-1:0]   r_ks_data;
  logic               r_done;

  logic               w_accept;
  logic               w_fire;
  logic               w_hs;
  logic               w_drained;
  logic               w_core_load;
  logic               w_core_en;
  logic [WIDTH-1:0]   w_ks_word;

`ifdef ABC_SEQ_XOR_EN
  assign w_ks_word = bus.core_ks ^ bus.pt_data;
`else
  assign w_ks_word = bus.core_ks;
`endif

  assign w_hs = r_ks_valid & bus.ks_ready;
  // Output register can take a new word (empty, or being emptied this cycle).
  assign w_drained = ~r_ks_valid | bus.ks_ready;

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_fire      = 1'b0;
    w_core_load = 1'b0;
    w_core_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_accept    = bus.key_valid;
        w_core_load = bus.key_valid;
        if (w_accept && (r_cnt == c_KEY_LAST)) w_next = c_AFTER_LOAD;
      end
      S_WARMUP: begin
        w_core_en = 1'b1;
        if (r_cnt == c_WARM_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        w_fire    = (r_remain != '0) & w_drained;
        w_core_en = w_fire;
        if ((r_remain == '0) && w_drained) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_remain   <= '0;
      r_ks_valid <= 1'b0;
      r_ks_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next;
      // done trails the DONE state by one register stage
      r_done  <= (r_state == S_DONE);

      if ((r_state == S_IDLE) && start) r_remain <= msg_len;

      if (r_state == S_LOAD) begin
        if (w_accept) r_cnt <= (r_cnt == c_KEY_LAST) ? '0 : r_cnt + 1'b1;
      end else if (r_state == S_WARMUP) begin
        r_cnt <= (r_cnt == c_WARM_LAST) ? '0 : r_cnt + 1'b1;
      end

      if (w_fire) begin
        r_ks_data  <= w_ks_word;
        r_ks_valid <= 1'b1;
        r_remain   <= r_remain - 1'b1;
      end else if (w_hs) begin
        r_ks_valid <= 1'b0;
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign bus.key_ready = (r_state == S_LOAD);
  assign bus.core_load = w_core_load;
  assign bus.core_seed = (r_state == S_LOAD) ? bus.key_data : '0;
  assign bus.core_en   = w_core_en;
  assign bus.ks_valid  = r_ks_valid;
  assign bus.ks_data   = r_ks_data;

endmodule
`default_nettype wire

// File: tb/tb_abc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_abc_seq
// Purpose  : Self-checking bench for abc_seq. Plays the key source, a
//            behavioural keystream core and the consumer; expected words of
//            each session are queued up front and popped by a monitor on
//            every keystream handshake.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_abc_seq;
  localparam int WIDTH = 32;
  localparam int KW    = 4;
  localparam int WU    = 32;
  localparam int LEN_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic             busy;
  logic             done;

  abc_seq_if #(.WIDTH(WIDTH)) bus ();

  abc_seq #(.WIDTH(WIDTH), .KEY_WORDS(KW), .WARMUP(WU), .LEN_W(LEN_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .msg_len (msg_len),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_en     = 0;
  int n_ld     = 0;
  int nwords   = 0;
  int rmode    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pt_v = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural keystream core: seeds fold into the state, each step is an
  // affine map, output is a simple whitening of the state.
  function automatic logic [31:0] rot8(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction
  function automatic logic [31:0] step(input logic [31:0] x);
    return x * 32'h9E37_79B1 + 32'h7F4A_7C15;
  endfunction
  function automatic logic [31:0] ksf(input logic [31:0] x);
    return x ^ (x >> 13);
  endfunction

  logic [31:0] core_s = '0;
  always @(posedge clock) begin
    if (!busy)              core_s <= '0;
    else if (bus.core_load) core_s <= rot8(core_s) ^ bus.core_seed;
    else if (bus.core_en)   core_s <= step(core_s);
  end
  assign bus.core_ks = ksf(core_s);
`ifdef ABC_SEQ_XOR_EN
  assign bus.pt_data = pt_v;
`endif

  // Consumer ready pattern: 0 = always ready, 1 = 1,0,0,1 cycle, 2 = random.
  initial begin
    bit [3:0] pat = 4'b1001;
    int rc = 0;
    bus.ks_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        1:       bus.ks_ready = pat[rc % 4];
        2:       bus.ks_ready = 1'($urandom % 2);
        default: bus.ks_ready = 1'b1;
      endcase
      rc++;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.core_en)   n_en++;
        if (bus.core_load) n_ld++;
        if (prev_stall) begin
          chk("stall_valid", bus.ks_valid, 1'b1);
          chk("stall_data", bus.ks_data, prev_data);
        end
        if (bus.ks_valid && !bus.ks_ready) chk("stall_core_en", bus.core_en, 1'b0);
        if (bus.ks_valid && bus.ks_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ks_extra: got %0h expected no word", bus.ks_data);
          end else begin
            chk("ks_data", bus.ks_data, exp_q.pop_front());
          end
          nwords++;
        end
        prev_stall = bus.ks_valid & ~bus.ks_ready;
        prev_data  = bus.ks_data;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, bus.key_ready, 1'b0);
    chk({tag, "_core_load"}, bus.core_load, 1'b0);
    chk({tag, "_core_seed"}, bus.core_seed, 32'h0);
    chk({tag, "_core_en"},   bus.core_en,   1'b0);
    chk({tag, "_ks_valid"},  bus.ks_valid,  1'b0);
    chk({tag, "_ks_data"},   bus.ks_data,   32'h0);
    chk({tag, "_busy"},      busy,          1'b0);
    chk({tag, "_done"},      done,          1'b0);
  endtask

  // kmode: 0 = key_valid held high, 1 = gapped key_valid with stray starts.
  // abort_after > 0: assert reset once that many words were delivered.
  task automatic session(input int len, input int kmode, input int rm,
                         input bit tcheck, input int abort_after,
                         input logic [31:0] pt_in);
    logic [31:0] seeds[KW];
    logic [31:0] s;
    logic [31:0] xm;
    int e0, kidx, bnd;
    bit hs, got;
`ifdef ABC_SEQ_XOR_EN
    xm = pt_in;
`else
    xm = 32'h0;
`endif
    pt_v  = pt_in;
    rmode = rm;
    s = '0;
    for (int k = 0; k < KW; k++) begin
      seeds[k] = $urandom;
      s = rot8(s) ^ seeds[k];
    end
    for (int k = 0; k < WU; k++) s = step(s);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(ksf(s) ^ xm);
      s = step(s);
    end

    @(posedge clock); #1;
    start   = 1'b1;
    msg_len = LEN_W'(len);
    n_en = 0; n_ld = 0; nwords = 0;
    @(posedge clock); #1;
    e0      = cyc;
    start   = 1'b0;
    msg_len = LEN_W'($urandom);

    kidx = 0;
    bnd  = 0;
    while (kidx < KW && bnd < 200) begin
      bus.key_valid = (kmode == 0) ? 1'b1 : 1'(bnd % 2 == 0);
      bus.key_data  = seeds[kidx];
      start         = (kmode == 1) && (bnd % 3 == 1);
      @(negedge clock);
      hs = bus.key_valid & bus.key_ready;
      @(posedge clock); #1;
      if (hs) kidx++;
      bnd++;
    end
    bus.key_valid = 1'b0;
    bus.key_data  = $urandom;
    start         = 1'b0;
    if (kidx < KW) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got %0d words accepted expected %0d", kidx, KW);
    end

    got = 1'b0;
    bnd = 0;
    while (!got && bnd < 3000) begin
      @(negedge clock);
      if (abort_after > 0 && nwords >= abort_after) begin
        reset = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        @(posedge clock); #2;
        reset = 1'b1;
        return;
      end
      if (done) got = 1'b1;
      bnd++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", bnd);
      return;
    end
    if (tcheck) chk("done_cycle", 64'(cyc - e0 + 1), 64'(1 + KW + WU + len + 2));
    chk("core_en_count",   64'(n_en),   64'(WU + len));
    chk("core_load_count", 64'(n_ld),   64'(KW));
    chk("words_delivered", 64'(nwords), 64'(len));
    chk("queue_empty",     64'(exp_q.size()), 64'(0));
    @(negedge clock);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_data  = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    bus.key_valid = 1'b1;
    bus.key_data  = 32'hDEAD_BEEF;
    #1;
    chk("reset_key_ignored_load", bus.core_load, 1'b0);
    chk("reset_key_ignored_seed", bus.core_seed, 32'h0);
    bus.key_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;

    session(8, 0, 0, 1'b1, 0, 32'h0);          // nominal: done in cycle 47
    session(8, 0, 1, 1'b0, 0, 32'h1234_5678);  // ready 1,0,0,1
    session(0, 0, 0, 1'b1, 0, 32'h0);          // empty message
    session(6, 1, 2, 1'b0, 0, 32'h0);          // gapped key, stray starts
    session(8, 0, 0, 1'b0, 3, 32'h0);          // reset after 3 of 8 words
    session(5, 0, 0, 1'b1, 0, 32'h0);          // clean reload after reset
    session(7, 0, 2, 1'b0, 0, 32'hFFFF_FFFF);  // all-ones plaintext
    for (int i = 0; i < 6; i++) begin
      session(int'($urandom_range(1, 12)), int'($urandom % 2),
              int'($urandom % 3), 1'b0, 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
